// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// Double-buffered frames: a load sits in a pending buffer and is committed to
// the active buffer only at a frame boundary or when scanning starts.
//
// Ports:
//   clk, rst_n   rising-edge clock, async active-low reset
//   enable       1 = scan, 0 = all digits dark (returns to IDLE)
//   load_valid   load_data holds a new frame (nibble k = load_data[4k+3:4k])
//   load_ready   pending buffer empty; a load is accepted on valid && ready
//   blank_mask   bit k = 1 keeps digit k dark
//   nibble_out   nibble for the shared segment decoder
//   digit_sel    one-hot active-high digit enable
//   frame_done   one-cycle pulse at the end of the last digit's dwell
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [TW-1:0]           timer, timer_nxt;
  logic                    commit;
  logic                    frame_done_nxt;
  logic [NUM_DIGITS-1:0]   sel_nxt;
  logic [3:0]              nibble_nxt;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pend_vld;

  assign load_ready = !pend_vld;

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    timer_nxt      = timer;
    commit         = 1'b0;
    frame_done_nxt = 1'b0;
    sel_nxt        = '0;
    nibble_nxt     = nibble_out;

    case (state)
      IDLE: begin
        if (enable) begin
          commit    = 1'b1;
          idx_nxt   = '0;
          timer_nxt = '0;
          state_nxt = BLANK;
        end
      end

      BLANK: begin
        if (!enable) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          timer_nxt = '0;
        end else begin
          // Nibble is settled during the dark gap so it never changes while lit.
          nibble_nxt = active[{idx, 2'b00} +: 4];
          if (timer == BLANK_LAST) begin
            state_nxt = SHOW;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
      end

      SHOW: begin
        if (!enable) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          timer_nxt = '0;
        end else begin
          // Enable is registered from the current SHOW state, so the lit window
          // trails the state by one clock but keeps exactly DWELL_CYCLES length.
          sel_nxt = (NUM_DIGITS'(1) << idx) & ~blank_mask;
          if (timer == DWELL_LAST) begin
            state_nxt = BLANK;
            timer_nxt = '0;
            if (idx == IDX_LAST) begin
              idx_nxt        = '0;
              frame_done_nxt = 1'b1;
              commit         = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      timer      <= '0;
      active     <= '0;
      pending    <= '0;
      pend_vld   <= 1'b0;
      nibble_out <= '0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      timer      <= timer_nxt;
      nibble_out <= nibble_nxt;
      digit_sel  <= sel_nxt;
      frame_done <= frame_done_nxt;
      // Commit looks at the registered pend_vld only; a load arriving on the
      // commit edge therefore waits for the following boundary.
      if (commit && pend_vld) begin
        active   <= pending;
        pend_vld <= 1'b0;
      end else if (load_valid && !pend_vld) begin
        pending  <= load_data;
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, DWELL_CYCLES=4,
// BLANK_CYCLES=2. Edge 0 is the clock edge that samples enable high in IDLE;
// outputs are sampled on the falling edge after each rising edge.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_ready;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  nibble_out;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int n_chk = 0;
  int n_err = 0;

  // Frame contents shown in frame f (frame f starts committing at edge 24*f).
  logic [15:0] frame_dat [0:3];

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .blank_mask(blank_mask),
    .nibble_out(nibble_out),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs after edge k of a scan that started at edge 0.
  // Digit d is lit after edges 3+6d .. 6+6d of each 24-clock frame.
  task automatic check_edge(input int k);
    logic [3:0]  e_sel;
    logic [3:0]  e_nib;
    logic        e_fd;
    logic [15:0] fd;
    int          q;
    int          f;
    int          d;
    e_sel = '0;
    e_nib = '0;
    e_fd  = (k > 0) && (k % 24 == 0);
    if (k >= 3) begin
      q = (k - 3) % 24;
      if (q % 6 < 4) e_sel = (4'b0001 << (q / 6)) & ~blank_mask;
    end
    chk($sformatf("sel@%0d", k), {28'd0, digit_sel}, {28'd0, e_sel});
    chk($sformatf("fdone@%0d", k), {31'd0, frame_done}, {31'd0, e_fd});
    if (k >= 1) begin
      f     = (k - 1) / 24;
      d     = ((k - 1) / 6) % 4;
      fd    = frame_dat[f];
      e_nib = fd[d*4 +: 4];
      chk($sformatf("nib@%0d", k), {28'd0, nibble_out}, {28'd0, e_nib});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got running, expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #1;
    chk("rst_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_sel",   {28'd0, digit_sel},  32'd0);
    chk("rst_nib",   {28'd0, nibble_out}, 32'd0);
    chk("rst_fdone", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_sel",   {28'd0, digit_sel},  32'd0);
    chk("idle_ready", {31'd0, load_ready}, 32'd1);

    // Load while IDLE
    load_valid = 1'b1;
    load_data  = 16'h4321;
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 16'h5555;
    chk("idle_load_ready", {31'd0, load_ready}, 32'd0);
    chk("idle_load_sel",   {28'd0, digit_sel},  32'd0);

    frame_dat[0] = 16'h4321;
    frame_dat[1] = 16'h9876;
    frame_dat[2] = 16'h9876;
    frame_dat[3] = 16'h9876;

    enable = 1'b1;
    @(negedge clk);
    check_edge(0);
    chk("commit_ready@0", {31'd0, load_ready}, 32'd1);

    for (int k = 1; k <= 88; k++) begin
      @(negedge clk);
      check_edge(k);
      if (k == 5) begin
        load_valid = 1'b1;
        load_data  = 16'h9876;
      end
      if (k == 6) begin
        chk("midload_ready@6", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b0;
      end
      if (k == 10) begin
        load_valid = 1'b1;
        load_data  = 16'hAAAA;
      end
      if (k == 11) begin
        chk("reject_ready@11", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b0;
      end
      if (k == 23) chk("ready@23", {31'd0, load_ready}, 32'd0);
      if (k == 24) chk("ready@24", {31'd0, load_ready}, 32'd1);
      if (k == 47) blank_mask = 4'b1000;
      if (k == 71) blank_mask = 4'b0000;
      if (k == 88) begin
        enable = 1'b0;
        break;
      end
    end

    // Enable dropped during digit 2's dwell
    @(negedge clk);
    chk("drop_sel",   {28'd0, digit_sel},  32'd0);
    chk("drop_fdone", {31'd0, frame_done}, 32'd0);
    chk("drop_ready", {31'd0, load_ready}, 32'd1);
    @(negedge clk);
    chk("drop_idle_sel", {28'd0, digit_sel}, 32'd0);

    // Re-enable: restart from digit 0 with the same committed frame
    frame_dat[0] = 16'h9876;
    frame_dat[1] = 16'h9876;
    enable = 1'b1;
    for (int k = 0; k <= 28; k++) begin
      @(negedge clk);
      check_edge(k);
    end

    // Asynchronous reset while digit 0 is lit
    chk("pre_rst_sel", {28'd0, digit_sel}, 32'd1);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("mid_rst_sel",   {28'd0, digit_sel},  32'd0);
    chk("mid_rst_nib",   {28'd0, nibble_out}, 32'd0);
    chk("mid_rst_ready", {31'd0, load_ready}, 32'd1);
    chk("mid_rst_fdone", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_sel%0d", i), {28'd0, digit_sel}, 32'd0);
    end

    frame_dat[0] = 16'h0000;
    enable = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      check_edge(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
